// File: rtl/seq_divider32_if.sv
// seq_divider32_if: divider operand/result bundle
// Signals: start, div_signed, dividend, divisor (requester -> divider);
//          busy, done, quotient, remainder, div_by_zero (divider -> requester).
interface seq_divider32_if #(parameter int WIDTH = 32);
    logic             start;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output start, div_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, div_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle restoring signed/unsigned divider feeding LO (quotient) and HI (remainder)
// Ports: clk (rising edge), clr (async active-low reset), bus (slave side of seq_divider32_if).
module seq_divider32 #(parameter int WIDTH = 32) (
    input logic            clk,
    input logic            clr,
    seq_divider32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] dvd, dvs, qr, mb, prem;
    logic             sgn, qneg, rneg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial;
    always_ff @(posedge clk or negedge clr)
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (bus.start ? PREP : IDLE) :
                   state == PREP ? (dvs == '0 ? DONE : ITER) :
                   state == ITER ? (cnt == CW'(WIDTH-1) ? FIX : ITER) :
                   state == FIX  ? DONE : IDLE;
    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == DONE;
    end
    // Shifted partial remainder needs WIDTH+1 bits; bit WIDTH of the trial is the borrow.
    // qr starts as the dividend magnitude and fills with quotient bits from the LSB.
    assign trial = {prem, qr[WIDTH-1]} - {1'b0, mb};
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            dvd             <= '0;
            dvs             <= '0;
            sgn             <= 1'b0;
            qr              <= '0;
            mb              <= '0;
            prem            <= '0;
            qneg            <= 1'b0;
            rneg            <= 1'b0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    dvd <= bus.dividend;
                    dvs <= bus.divisor;
                    sgn <= bus.div_signed;
                end
                PREP: if (dvs == '0) begin
                    bus.quotient    <= '1;
                    bus.remainder   <= dvd;
                    bus.div_by_zero <= 1'b1;
                end else begin
                    qr   <= sgn && dvd[WIDTH-1] ? -dvd : dvd;
                    mb   <= sgn && dvs[WIDTH-1] ? -dvs : dvs;
                    qneg <= sgn & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
                    rneg <= sgn & dvd[WIDTH-1];
                    prem <= '0;
                    cnt  <= '0;
                end
                ITER: begin
                    // On a borrow the shifted value is below the divisor, so its top bit is 0.
                    prem <= trial[WIDTH] ? {prem[WIDTH-2:0], qr[WIDTH-1]} : trial[WIDTH-1:0];
                    qr   <= {qr[WIDTH-2:0], ~trial[WIDTH]};
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    bus.quotient    <= qneg ? -qr : qr;
                    bus.remainder   <= rneg ? -prem : prem;
                    bus.div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
endmodule
